// File: rtl/cv32e40x_rvfi_pkg.sv
// Shared types for the RVFI instruction pipe.
// Holds the OBI fetch packet layout, the per-stage shadow record and the
// fetch-fault helper used when a record is retired.
package cv32e40x_rvfi_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned PROT_W = 3;

    typedef enum logic [1:0] {
        MPU_OK       = 2'b00,
        MPU_RE_FAULT = 2'b01,
        MPU_WR_FAULT = 2'b10,
        MPU_WE_FAULT = 2'b11
    } mpu_status_e;

    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic [PROT_W-1:0] prot;
    } obi_inst_req_t;

    typedef struct packed {
        logic [XLEN-1:0] rdata;
        logic            err;
    } obi_inst_resp_t;

    typedef struct packed {
        obi_inst_resp_t bus_resp;
        mpu_status_e    mpu_status;
    } inst_resp_t;

    typedef struct packed {
        obi_inst_req_t req_payload;
        inst_resp_t    resp_payload;
    } rvfi_obi_instr_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic            compressed;
        rvfi_obi_instr_t obi_instr;
    } rvfi_instr_stage_t;

    // A fetch faulted if the bus reported an error or the MPU blocked it.
    function automatic logic rvfi_fetch_fault(logic err, mpu_status_e mpu_status);
        return err || (mpu_status != MPU_OK);
    endfunction

endpackage

// File: rtl/cv32e40x_rvfi_instr_stage.sv
// One shadow pipeline stage register for the RVFI instruction pipe.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   load_i                - capture new payload and mark valid
//   leave_i               - current payload moves downstream this cycle
//   kill_i                - flush; beats both load and leave
//   pc_i, compressed_i,
//   obi_instr_i           - payload to capture on load
//   stage_o               - registered stage contents
module cv32e40x_rvfi_instr_stage
    import cv32e40x_rvfi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              leave_i,
    input  logic              kill_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              compressed_i,
    input  rvfi_obi_instr_t   obi_instr_i,
    output rvfi_instr_stage_t stage_o
);

    rvfi_instr_stage_t stage_q;
    rvfi_instr_stage_t stage_d;

    // Load wins over leave; kill wins over everything.
    always_comb begin
        stage_d = stage_q;
        if (load_i) begin
            stage_d.valid      = 1'b1;
            stage_d.pc         = pc_i;
            stage_d.compressed = compressed_i;
            stage_d.obi_instr  = obi_instr_i;
        end else if (leave_i) begin
            stage_d.valid = 1'b0;
        end
        if (kill_i) begin
            stage_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/cv32e40x_rvfi_instr_pipe.sv
// Shadow ID/EX/WB pipeline for the IF-timed RVFI OBI instruction packet.
// Follows the core handshakes and kills and emits a registered fetch record
// with a retirement order on every retire.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   if_valid_i, id_ready_i           - IF->ID handshake
//   if_instr_i, if_pc_i,
//   if_compressed_i                  - IF-aligned payload
//   id_valid_i, ex_ready_i           - ID->EX handshake
//   ex_valid_i, wb_ready_i           - EX->WB handshake
//   wb_valid_i                       - WB retires this cycle
//   kill_id_i, kill_ex_i, kill_wb_i  - per-stage flushes
//   rvfi_*_o                         - registered retire record
module cv32e40x_rvfi_instr_pipe
    import cv32e40x_rvfi_pkg::*;
#(
    parameter int unsigned ORDER_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_valid_i,
    input  logic                id_ready_i,
    input  rvfi_obi_instr_t     if_instr_i,
    input  logic [XLEN-1:0]     if_pc_i,
    input  logic                if_compressed_i,
    input  logic                id_valid_i,
    input  logic                ex_ready_i,
    input  logic                ex_valid_i,
    input  logic                wb_ready_i,
    input  logic                wb_valid_i,
    input  logic                kill_id_i,
    input  logic                kill_ex_i,
    input  logic                kill_wb_i,
    output logic                rvfi_valid_o,
    output logic [ORDER_W-1:0]  rvfi_order_o,
    output logic [XLEN-1:0]     rvfi_pc_o,
    output logic [XLEN-1:0]     rvfi_insn_o,
    output rvfi_obi_instr_t     rvfi_instr_obi_o,
    output logic                rvfi_fetch_fault_o
);

    rvfi_instr_stage_t id_stage;
    rvfi_instr_stage_t ex_stage;
    rvfi_instr_stage_t wb_stage;

    logic id_load;
    logic ex_load;
    logic wb_load;
    logic retire;

    // Transfers; a kill on either side of a boundary blocks the move.
    assign id_load = if_valid_i && id_ready_i && !kill_id_i;
    assign ex_load = id_valid_i && ex_ready_i && id_stage.valid && !kill_id_i && !kill_ex_i;
    assign wb_load = ex_valid_i && wb_ready_i && ex_stage.valid && !kill_ex_i && !kill_wb_i;
    assign retire  = wb_valid_i && wb_stage.valid && !kill_wb_i;

    cv32e40x_rvfi_instr_stage u_id_stage (
        .clk          (clk),
        .rst          (rst),
        .load_i       (id_load),
        .leave_i      (ex_load),
        .kill_i       (kill_id_i),
        .pc_i         (if_pc_i),
        .compressed_i (if_compressed_i),
        .obi_instr_i  (if_instr_i),
        .stage_o      (id_stage)
    );

    cv32e40x_rvfi_instr_stage u_ex_stage (
        .clk          (clk),
        .rst          (rst),
        .load_i       (ex_load),
        .leave_i      (wb_load),
        .kill_i       (kill_ex_i),
        .pc_i         (id_stage.pc),
        .compressed_i (id_stage.compressed),
        .obi_instr_i  (id_stage.obi_instr),
        .stage_o      (ex_stage)
    );

    cv32e40x_rvfi_instr_stage u_wb_stage (
        .clk          (clk),
        .rst          (rst),
        .load_i       (wb_load),
        .leave_i      (retire),
        .kill_i       (kill_wb_i),
        .pc_i         (ex_stage.pc),
        .compressed_i (ex_stage.compressed),
        .obi_instr_i  (ex_stage.obi_instr),
        .stage_o      (wb_stage)
    );

    // The compressed flag travels with the entry but the record reports the
    // already zero-extended word, so it is not needed at retirement.
    logic wb_compressed_unused;
    assign wb_compressed_unused = wb_stage.compressed;

    logic [ORDER_W-1:0] order_q;
    logic [ORDER_W-1:0] order_d;
    logic               rvfi_valid_q;
    logic               rvfi_valid_d;
    logic [ORDER_W-1:0] rvfi_order_q;
    logic [ORDER_W-1:0] rvfi_order_d;
    logic [XLEN-1:0]    rvfi_pc_q;
    logic [XLEN-1:0]    rvfi_pc_d;
    logic [XLEN-1:0]    rvfi_insn_q;
    logic [XLEN-1:0]    rvfi_insn_d;
    rvfi_obi_instr_t    rvfi_obi_q;
    rvfi_obi_instr_t    rvfi_obi_d;
    logic               rvfi_fault_q;
    logic               rvfi_fault_d;

    // Retire record: payload holds between retires, order wraps naturally.
    always_comb begin
        order_d      = order_q;
        rvfi_valid_d = retire;
        rvfi_order_d = rvfi_order_q;
        rvfi_pc_d    = rvfi_pc_q;
        rvfi_insn_d  = rvfi_insn_q;
        rvfi_obi_d   = rvfi_obi_q;
        rvfi_fault_d = rvfi_fault_q;
        if (retire) begin
            order_d      = order_q + ORDER_W'(1);
            rvfi_order_d = order_q;
            rvfi_pc_d    = wb_stage.pc;
            rvfi_insn_d  = wb_stage.obi_instr.resp_payload.bus_resp.rdata;
            rvfi_obi_d   = wb_stage.obi_instr;
            rvfi_fault_d = rvfi_fetch_fault(wb_stage.obi_instr.resp_payload.bus_resp.err,
                                            wb_stage.obi_instr.resp_payload.mpu_status);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            order_q      <= '0;
            rvfi_valid_q <= 1'b0;
            rvfi_order_q <= '0;
            rvfi_pc_q    <= '0;
            rvfi_insn_q  <= '0;
            rvfi_obi_q   <= '0;
            rvfi_fault_q <= 1'b0;
        end else begin
            order_q      <= order_d;
            rvfi_valid_q <= rvfi_valid_d;
            rvfi_order_q <= rvfi_order_d;
            rvfi_pc_q    <= rvfi_pc_d;
            rvfi_insn_q  <= rvfi_insn_d;
            rvfi_obi_q   <= rvfi_obi_d;
            rvfi_fault_q <= rvfi_fault_d;
        end
    end

    assign rvfi_valid_o       = rvfi_valid_q;
    assign rvfi_order_o       = rvfi_order_q;
    assign rvfi_pc_o          = rvfi_pc_q;
    assign rvfi_insn_o        = rvfi_insn_q;
    assign rvfi_instr_obi_o   = rvfi_obi_q;
    assign rvfi_fetch_fault_o = rvfi_fault_q;

    // WB must hold an instruction whenever the core claims to retire one.
    a_no_retire_from_empty_wb: assert property (
        @(posedge clk) disable iff (rst) wb_valid_i |-> wb_stage.valid
    );

endmodule

// File: doc/cv32e40x_rvfi_instr_pipe.md
Name: cv32e40x_rvfi_instr_pipe

Overview:
- Downstream consumer of the RVFI instruction OBI packet (rvfi_obi_instr_t) produced at IF timing.
- Carries the packet, PC and compressed flag through shadow ID, EX and WB stage registers that follow the core pipeline handshakes and kills.
- On retirement, emits a registered RVFI fetch record with a 64-bit retirement order and a fetch-fault flag.
- Sits in the RVFI bind hierarchy, between the IF-timed OBI packet source and the RVFI output packer.

Parameters:
- ORDER_W, 64, width of the retirement order counter.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous, active-high reset.
- if_valid_i  input  1  IF stage holds a valid instruction.
- id_ready_i  input  1  ID accepts from IF.
- if_instr_i  input  rvfi_obi_instr_t  OBI packet aligned to IF.
- if_pc_i  input  32  IF instruction address.
- if_compressed_i  input  1  IF instruction is 16-bit.
- id_valid_i  input  1  ID presents to EX.
- ex_ready_i  input  1  EX accepts from ID.
- ex_valid_i  input  1  EX presents to WB.
- wb_ready_i  input  1  WB accepts from EX.
- wb_valid_i  input  1  WB retires its instruction this cycle.
- kill_id_i  input  1  flush ID.
- kill_ex_i  input  1  flush EX.
- kill_wb_i  input  1  flush WB.
- rvfi_valid_o  output  1  registered retire strobe.
- rvfi_order_o  output  ORDER_W  order of the retired instruction.
- rvfi_pc_o  output  32  retired PC.
- rvfi_insn_o  output  32  retired instruction word; bits [31:16] are 0 when compressed.
- rvfi_instr_obi_o  output  rvfi_obi_instr_t  retired OBI packet.
- rvfi_fetch_fault_o  output  1  bus err set or mpu_status != MPU_OK.

Behaviour:
- Reset: the design has one clock; reset is synchronous and active-high. Under reset, all stage valids, rvfi_valid_o, rvfi_order_o, rvfi_pc_o, rvfi_insn_o, rvfi_instr_obi_o and rvfi_fetch_fault_o are 0. The order counter is 0.
- Stage registers: ID, EX and WB each hold a valid bit plus payload {pc, compressed, obi_instr}.
- IF->ID: when if_valid_i && id_ready_i && !kill_id_i, ID loads the IF inputs and sets valid.
- ID->EX: when id_valid_i && ex_ready_i && id_q.valid && !kill_id_i && !kill_ex_i, EX loads ID.
- EX->WB: when ex_valid_i && wb_ready_i && ex_q.valid && !kill_ex_i && !kill_wb_i, WB loads EX.
- A stage whose payload leaves and that receives no new load clears its valid. A simultaneous load and leave in the same stage takes the new payload.
- Kill: kill_X_i clears stage X valid on the next edge. Kill takes priority over any load into X and suppresses any transfer out of X. Multiple kills in one cycle are independent.
- Retire: occurs when wb_valid_i && wb_q.valid && !kill_wb_i. On the next edge:
  - rvfi_valid_o = 1.
  - rvfi_order_o = order_q.
  - order_q increments by 1; it wraps from all-ones to 0.
  - Payload outputs are loaded from WB; WB valid clears unless EX->WB loads in the same cycle.
- Non-retire cycles: rvfi_valid_o = 0 and the payload outputs hold their last values.
- rvfi_insn_o = obi_instr.resp_payload.bus_resp.rdata, passed through as-is (the upstream packet already zero-extends compressed instructions).
- Latency: IF accept in cycle N with no stalls gives ID valid at N+1, EX at N+2 and WB at N+3. Retire in N+3 gives rvfi_valid_o high in N+4.
- wb_valid_i with an empty WB stage: ignored; the counter does not move. This is an illegal protocol condition and is covered by an assertion.
- Stalls (ready low) hold the stage contents indefinitely. Back-to-back retirement gives one rvfi_valid_o per cycle.
- Reset mid-operation: all in-flight entries are discarded and order restarts at 0.

Decomposition:
- cv32e40x_rvfi_pkg gets:
  - typedef rvfi_instr_stage_t {logic valid; logic [31:0] pc; logic compressed; rvfi_obi_instr_t obi_instr;}.
  - A fetch-fault helper function (err || mpu_status != MPU_OK).
- Sub-module cv32e40x_rvfi_instr_stage: one stage register with load/leave/kill inputs, instantiated three times.

Test Plan:
- Single instruction: PC 0x80, word 0x00A00093, no stalls, accepted in cycle 1 -> rvfi_valid_o=1 in cycle 5, rvfi_order_o=0, rvfi_insn_o=0x00A00093.
- Compressed instruction: rdata 0x00004501, compressed=1, then a 32-bit instruction -> orders 0 and 1 in consecutive cycles, rvfi_insn_o=0x00004501 then the 32-bit word.
- Kill EX while WB is stalled (wb_ready_i=0 for 3 cycles): 3 instructions in flight, kill_ex_i pulsed -> only the WB instruction retires, next retired order = previous+1 with no gaps.
- Fault: mpu_status=MPU_RE_FAULT on the packet -> rvfi_fetch_fault_o=1; bus err=1 -> 1; clean packet -> 0.
- Counter wrap: order_q forced to 2^64-1 and two instructions retired -> rvfi_order_o=0xFFFF_FFFF_FFFF_FFFF then 0.
- Reset asserted mid-stream with all 3 stages full -> next cycle all outputs are 0; after release, the first retire has order 0.
